// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: operating modes and the
// width helper used for level and pointer sizing.
package fifo_pkg;

  localparam int FIFO_MODE_FWFT = 1;
  localparam int FIFO_MODE_REG  = 0;

  // Ceiling log2, minimum 1 bit wide for any value above 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Synchronous FIFO controller for any depth: pointers, level, threshold flags,
// sticky error flags and either first-word-fall-through or registered output.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int WIDTH    = 8,
  parameter int FWFT     = FIFO_MODE_FWFT,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int LW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             write,
  input  logic [WIDTH-1:0] write_data,
  input  logic             read,
  output logic [WIDTH-1:0] read_data,
  output logic             read_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clear_err
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_acc = read & ~empty;
  assign wr_acc = write & (~full | rd_acc);

  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_LEVEL));
  assign almost_empty = (level <= LW'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      level <= level + 1'b1;
      else if (rd_acc && !wr_acc) level <= level - 1'b1;
    end
  end

  // A new error in the same cycle as clear_err must survive the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write & ~wr_acc & ~flush) | (overflow & ~clear_err);
      underflow <= (read & ~rd_acc & ~flush) | (underflow & ~clear_err);
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~flush & ~reset),
    .waddr (wr_ptr),
    .wdata (write_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign read_data  = ram_rdata;
      assign read_valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc & ~flush;
          if (rd_acc && !flush) data_q <= ram_rdata;
        end
      end

      assign read_data  = data_q;
      assign read_valid = valid_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Parametrised synchronous FIFO for controller data paths (UART byte streams, memory-bus word queues). Any depth, not only powers of two. Supports simultaneous read and write, and either first-word-fall-through or registered output. Adds level reporting, programmable almost-full/almost-empty thresholds, flush, and sticky overflow/underflow flags for host-visible error reporting.

## Interface
- DEPTH, 8: number of entries, ≥2, any integer.
- WIDTH, 8: data word width, ≥1.
- FWFT, 1: 1 = head word shown combinationally; 0 = registered read with one-cycle latency.
- AF_LEVEL, DEPTH-1: almost_full asserts when level ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 1: almost_empty asserts when level ≤ AE_LEVEL (0..DEPTH-1).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all contents.
- write  in  1  write request.
- write_data  in  WIDTH  word to enqueue.
- read  in  1  read (pop) request.
- read_data  out  WIDTH  head word (FWFT=1) or popped word (FWFT=0).
- read_valid  out  1  FWFT=1: equals !empty; FWFT=0: one-cycle pulse marking read_data as new.
- full, empty  out  1  occupancy flags.
- almost_full, almost_empty  out  1  threshold flags.
- level  out  LW = clog2(DEPTH+1)  current entry count.
- overflow, underflow  out  1  sticky error flags.
- clear_err  in  1  clears overflow/underflow.

## Operation
- wr_acc = write & (!full | rd_acc); rd_acc = read & !empty. A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- Both accepted: level unchanged, both pointers advance. Write only: level+1. Read only: level−1.
- Read on empty with write: read rejected, write accepted. There is no bypass of an empty FIFO.
- Pointers range 0..DEPTH-1 and wrap to 0 after DEPTH-1. No power-of-two arithmetic.
- full = (level == DEPTH). empty = (level == 0). almost_* are compares on the registered level.
- overflow sets when write & !wr_acc. underflow sets when read & !rd_acc. Both hold until clear_err or reset. Setting in the same cycle as clear_err wins.
- flush: pointers and level go to 0, and any read/write that cycle is ignored. Error flags are kept. A flush with FWFT=0 does not pulse read_valid.
- reset: same as flush, plus overflow=underflow=0, read_valid=0, and read_data register = 0 (FWFT=0).
- Memory contents are not reset. With FWFT=1, read_data is don't-care while empty.

## Timing
- Reset values: level 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, read_valid 0.
- All flags and level change on the clock edge after the accepted operation; there are no combinational paths from write/read to flags.
- FWFT=1: a word written at edge N is visible on read_data after edge N. With read asserted before edge N+1, the next word appears after edge N+1.
- FWFT=0: read accepted at edge N gives read_data and read_valid=1 after edge N, for one cycle. read_data holds its value afterwards.
- Back-to-back reads every cycle sustain 1 word/cycle in both modes.
- Flush or reset mid-stream takes effect at that edge; in-flight FWFT=0 output from the prior edge is unaffected.

## Structure
- Shared package fifo_pkg: level-width function clog2, and mode constants FIFO_MODE_FWFT=1 and FIFO_MODE_REG=0.
- Sub-module fifo_ram: WIDTH×DEPTH array with one synchronous write port and one asynchronous read port. It is instantiated once; the control logic (pointers, level, flags, errors, output register) stays in sync_fifo_ctl.

## Test plan
- DEPTH=5, FWFT=1: write 0x11..0x55, then 0x66 → full=1, overflow=1, level=5. Read 5 words → 0x11..0x55 in order, empty=1.
- DEPTH=5: fill 3, then 20 cycles of simultaneous read+write with an incrementing pattern → level stays 3, pointers wrap, data order preserved.
- Full FIFO with write+read in the same cycle → both accepted, overflow stays 0, level stays 5.
- FWFT=0: write 0xA5, read one cycle later → read_data=0xA5 with read_valid=1 exactly one cycle. Read on empty → underflow=1; clear_err → 0.
- AF_LEVEL=4, AE_LEVEL=1: levels 0..5 → almost_empty=1 at levels 0 and 1 only, almost_full=1 at levels 4 and 5 only.
- At level 3 with an error set: flush with write asserted → level=0, empty=1, error kept. Then reset → all outputs at reset values.
